seq_divider: RTL and testbench

- Parametrised multi-cycle restoring divider. Successor to the fixed 8-bit divider unit.
- Adds a configurable operand width, a per-operation signed/unsigned mode, divide-by-zero and signed-overflow flags, a busy indication, and deterministic latency.
- Sits beside the datapath as a start/done co-processor and produces one quotient bit per clock.

---
 rtl/seq_divider_if.sv | 26 ++
 rtl/seq_divider.sv | 145 ++++++++++++++
 tb/tb_seq_divider.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Start/done handshake and result bus for the sequential divider.
// The divider side uses the slave modport; the requester uses master.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             busy;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, signed_mode, x, y,
        input  quotient, remainder, done, busy, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_mode, x, y,
        output quotient, remainder, done, busy, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or unsigned
// per operation, with divide-by-zero and signed-overflow flags.
module seq_divider #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    seq_divider_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
        return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v, input logic is_neg);
        return is_neg ? neg_f(v) : v;
    endfunction

    state_t           state_r, next_state_s;
    logic             accept_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dvs_r;
    logic             sgn_r, x_neg_r, y_neg_r, ovf_cand_r;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             done_r, busy_r, dbz_r, ovf_r;
    logic             x_neg_s, y_neg_s, y_zero_s;
    logic [WIDTH:0]   shifted_s, trial_s;

    assign x_neg_s  = bus.signed_mode & bus.x[WIDTH-1];
    assign y_neg_s  = bus.signed_mode & bus.y[WIDTH-1];
    assign y_zero_s = (bus.y == {WIDTH{1'b0}});

    // The partial remainder never exceeds the divisor magnitude, so its top bit is free for the shift.
    assign shifted_s = {rem_r[WIDTH-1:0], dvd_r[WIDTH-1]};
    assign trial_s   = shifted_s - {1'b0, dvs_r};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    accept_s     = 1'b1;
                    next_state_s = y_zero_s ? DONE : CALC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_W'(1)) begin
                    next_state_s = FIX;
                end else begin
                    next_state_s = CALC;
                end
            end
            FIX:     next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and registered results/status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r       <= {CNT_W{1'b0}};
            rem_r       <= {(WIDTH+1){1'b0}};
            dvd_r       <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            sgn_r       <= 1'b0;
            x_neg_r     <= 1'b0;
            y_neg_r     <= 1'b0;
            ovf_cand_r  <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            done_r <= (next_state_s == DONE);
            busy_r <= (next_state_s == CALC) || (next_state_s == FIX);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sgn_r      <= bus.signed_mode;
                        x_neg_r    <= x_neg_s;
                        y_neg_r    <= y_neg_s;
                        dvd_r      <= mag_f(bus.x, x_neg_s);
                        dvs_r      <= mag_f(bus.y, y_neg_s);
                        rem_r      <= {(WIDTH+1){1'b0}};
                        cnt_r      <= CNT_W'(WIDTH);
                        ovf_cand_r <= bus.signed_mode
                                      && (bus.x == {1'b1, {(WIDTH-1){1'b0}}})
                                      && (bus.y == {WIDTH{1'b1}});
                        dbz_r      <= y_zero_s;
                        ovf_r      <= 1'b0;
                        // Divide-by-zero skips the iteration, so its results are loaded now.
                        if (y_zero_s) begin
                            quotient_r  <= {WIDTH{1'b1}};
                            remainder_r <= bus.x;
                        end
                    end
                end
                CALC: begin
                    rem_r <= trial_s[WIDTH] ? shifted_s : trial_s;
                    dvd_r <= {dvd_r[WIDTH-2:0], ~trial_s[WIDTH]};
                    cnt_r <= cnt_r - CNT_W'(1);
                end
                FIX: begin
                    quotient_r  <= mag_f(dvd_r, sgn_r & (x_neg_r ^ y_neg_r));
                    remainder_r <= mag_f(rem_r[WIDTH-1:0], sgn_r & x_neg_r);
                    ovf_r       <= ovf_cand_r;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.done        = done_r;
    assign bus.busy        = busy_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.overflow    = ovf_r;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=8 and WIDTH=16: directed cases,
// latency/busy timing, ignored start, mid-operation reset and random sweeps.
module tb_seq_divider;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(8))  b8 ();
    seq_divider_if #(.WIDTH(16)) b16 ();

    seq_divider #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(b8));
    seq_divider #(.WIDTH(16)) u16 (.clk(clk), .reset(reset), .bus(b16));

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference: plain integer division, truncating toward zero, remainder follows dividend.
    function automatic exp_t model(input int w, input bit sm, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint m, half, sa, sb, q, r;
        m    = (longint'(1) << w) - 1;
        half = (m + 1) / 2;
        e.dz = 1'b0;
        e.ov = 1'b0;
        if (b == 32'd0) begin
            e.q  = 32'(m);
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            sa = longint'(a);
            sb = longint'(b);
            if (sm) begin
                if (sa >= half) sa = sa - (m + 1);
                if (sb >= half) sb = sb - (m + 1);
            end
            q    = sa / sb;
            r    = sa % sb;
            e.ov = sm && (q >= half);
            e.q  = 32'(q & m);
            e.r  = 32'(r & m);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor for the 8-bit instance: every done pulse must match the oldest expectation.
    always @(negedge clk) begin : mon8
        exp_t e;
        if (reset === 1'b1 && b8.done === 1'b1) begin
            if (q8.size() == 0) begin
                fail_now("spurious_done8");
            end else begin
                e = q8.pop_front();
                chk("quotient8", 32'(b8.quotient), e.q);
                chk("remainder8", 32'(b8.remainder), e.r);
                chk("div_by_zero8", 32'(b8.div_by_zero), 32'(e.dz));
                chk("overflow8", 32'(b8.overflow), 32'(e.ov));
            end
        end
    end

    // Monitor for the 16-bit instance.
    always @(negedge clk) begin : mon16
        exp_t e;
        if (reset === 1'b1 && b16.done === 1'b1) begin
            if (q16.size() == 0) begin
                fail_now("spurious_done16");
            end else begin
                e = q16.pop_front();
                chk("quotient16", 32'(b16.quotient), e.q);
                chk("remainder16", 32'(b16.remainder), e.r);
                chk("div_by_zero16", 32'(b16.div_by_zero), 32'(e.dz));
                chk("overflow16", 32'(b16.overflow), 32'(e.ov));
            end
        end
    end

    task automatic start_op(input int w, input bit sm, input logic [31:0] a, input logic [31:0] b, input bit push);
        @(negedge clk);
        if (w == 8) begin
            b8.start       = 1'b1;
            b8.signed_mode = sm;
            b8.x           = a[7:0];
            b8.y           = b[7:0];
            if (push) q8.push_back(model(8, sm, a & 32'hFF, b & 32'hFF));
        end else begin
            b16.start       = 1'b1;
            b16.signed_mode = sm;
            b16.x           = a[15:0];
            b16.y           = b[15:0];
            if (push) q16.push_back(model(16, sm, a & 32'hFFFF, b & 32'hFFFF));
        end
        @(negedge clk);
        b8.start  = 1'b0;
        b16.start = 1'b0;
    endtask

    // Called at the negedge of cycle cyc0 after the start cycle; counts cycles until done.
    task automatic wait_done(input int w, input int cyc0, input int exp_lat, input int exp_busy);
        int   cyc;
        int   nb;
        logic d;
        cyc = cyc0;
        nb  = 0;
        d   = (w == 8) ? b8.done : b16.done;
        while (d !== 1'b1 && cyc < 60) begin
            if (((w == 8) ? b8.busy : b16.busy) === 1'b1) nb++;
            @(negedge clk);
            cyc++;
            d = (w == 8) ? b8.done : b16.done;
        end
        if (d !== 1'b1) begin
            fail_now("done_timeout");
        end else begin
            chk("latency", 32'(cyc), 32'(exp_lat));
            if (exp_busy >= 0) chk("busy_cycles", 32'(nb), 32'(exp_busy));
        end
    endtask

    task automatic run(input int w, input bit sm, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] bm;
        bm = (w == 8) ? (b & 32'hFF) : (b & 32'hFFFF);
        start_op(w, sm, a, b, 1'b1);
        if (bm == 32'd0) wait_done(w, 1, 1, -1);
        else             wait_done(w, 1, w + 2, w + 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        bit          sm;
        reset           = 1'b0;
        b8.start        = 1'b0;
        b8.signed_mode  = 1'b0;
        b8.x            = 8'd0;
        b8.y            = 8'd0;
        b16.start       = 1'b0;
        b16.signed_mode = 1'b0;
        b16.x           = 16'd0;
        b16.y           = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_quotient", 32'(b8.quotient), 32'd0);
        chk("reset_remainder", 32'(b8.remainder), 32'd0);
        chk("reset_done", 32'(b8.done), 32'd0);
        chk("reset_busy", 32'(b8.busy), 32'd0);
        chk("reset_dbz", 32'(b8.div_by_zero), 32'd0);
        chk("reset_ovf", 32'(b8.overflow), 32'd0);
        reset = 1'b1;

        // Directed WIDTH=8 cases.
        run(8, 1'b0, 32'd8,    32'd13);
        run(8, 1'b0, 32'd200,  32'd7);
        run(8, 1'b1, 32'hF9,   32'd2);
        run(8, 1'b1, 32'd7,    32'hFE);
        run(8, 1'b1, 32'h80,   32'hFF);
        run(8, 1'b0, 32'h80,   32'hFF);
        run(8, 1'b1, 32'h5A,   32'd0);
        run(8, 1'b0, 32'h5A,   32'd0);
        run(8, 1'b0, 32'd100,  32'd9);

        // A start pulse in cycle 4 of an operation must be ignored.
        start_op(8, 1'b0, 32'd77, 32'd5, 1'b1);
        repeat (2) @(negedge clk);
        start_op(8, 1'b1, 32'd3, 32'd0, 1'b0);
        wait_done(8, 5, 10, 5);
        run(8, 1'b1, 32'hC4, 32'd5);

        // Reset in the middle of CALC abandons the operation.
        start_op(8, 1'b0, 32'd250, 32'd3, 1'b1);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_quotient", 32'(b8.quotient), 32'd0);
        chk("midreset_remainder", 32'(b8.remainder), 32'd0);
        chk("midreset_done", 32'(b8.done), 32'd0);
        chk("midreset_busy", 32'(b8.busy), 32'd0);
        chk("midreset_dbz", 32'(b8.div_by_zero), 32'd0);
        void'(q8.pop_back());
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_done_after_reset", 32'(b8.done), 32'd0);
        end
        run(8, 1'b0, 32'd100, 32'd10);

        // Random sweeps at both widths and both modes, with forced corner operands.
        for (int i = 0; i < 120; i++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 11) == 0) ? 32'd0 : $urandom;
            sm = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                a = 32'h80;
                b = 32'hFF;
            end
            run(8, sm, a, b);
        end
        for (int i = 0; i < 80; i++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 11) == 0) ? 32'd0 : $urandom;
            sm = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                a = 32'h8000;
                b = 32'hFFFF;
            end else if ($urandom_range(0, 3) == 0) begin
                b = b & 32'h3F;
            end
            run(16, sm, a, b);
        end

        repeat (3) @(negedge clk);
        chk("pending8", 32'(q8.size()), 32'd0);
        chk("pending16", 32'(q16.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
